// File: rtl/pc_pkg.sv
// Shared encodings for the next-PC / fetch block: pc_src values, fetch FSM states, reset vector.
package pc_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_JR  = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
    localparam int          JFIELD_W          = 28;

endpackage

// File: rtl/pc_target_sel.sv
// Combinational branch/jump/jr target formation and the next-PC priority mux
// (live redirect > pending redirect > sequential).
module pc_target_sel
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]     pc_plus4,
    input  logic                redirect_valid,
    input  logic [1:0]          pc_src,
    input  logic [XLEN-1:0]     br_off,
    input  logic [JFIELD_W-1:0] jaddr_sh,
    input  logic [XLEN-1:0]     jr_addr,
    input  logic                pend_v,
    input  logic [XLEN-1:0]     pend_tgt,
    output logic                live_v,
    output logic [XLEN-1:0]     live_tgt,
    output logic [XLEN-1:0]     next_pc
);

    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] j_tgt;

    assign br_tgt = pc_plus4 + br_off;
    assign j_tgt  = {pc_plus4[XLEN-1:JFIELD_W], jaddr_sh};

    // A "redirect" that selects the sequential path is not a control transfer.
    assign live_v = redirect_valid && (pc_src_e'(pc_src) != PCSRC_SEQ);

    always_comb begin
        live_tgt = pc_plus4;
        case (pc_src_e'(pc_src))
            PCSRC_BR: live_tgt = br_tgt;
            PCSRC_J:  live_tgt = j_tgt;
            PCSRC_JR: live_tgt = jr_addr;
            default:  live_tgt = pc_plus4;
        endcase
    end

    always_comb begin
        next_pc = pc_plus4;
        if (live_v)
            next_pc = live_tgt;
        else if (pend_v)
            next_pc = pend_tgt;
    end

endmodule

// File: rtl/pc_next_fetch.sv
// PC register, fetch req/ack FSM and one-entry redirect buffer.
// Optional feature macro: PC_ALIGN_CHECK_EN (misalign output, sticky halt on unaligned next_pc).
module pc_next_fetch
    import pc_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(RESET_VEC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [1:0]          pc_src,
    input  logic [XLEN-1:0]     br_off,
    input  logic [JFIELD_W-1:0] jaddr_sh,
    input  logic [XLEN-1:0]     jr_addr,
    input  logic                stall,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ack,
`ifdef PC_ALIGN_CHECK_EN
    output logic                misalign,
`endif
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4
);

    state_e          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic            req_reg;
    logic            pend_v_reg;
    logic [XLEN-1:0] pend_tgt_reg;

    logic            live_v;
    logic [XLEN-1:0] live_tgt;
    logic [XLEN-1:0] next_pc_raw;
    logic [XLEN-1:0] next_pc_eff;
    logic            accept;
    logic            align_fault;
    logic            halted;

    assign pc_plus4  = pc_reg + XLEN'(4);
    assign pc        = pc_reg;
    assign imem_addr = pc_reg;
    assign imem_req  = req_reg;

    pc_target_sel #(.XLEN(XLEN)) u_sel (
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .pc_src         (pc_src),
        .br_off         (br_off),
        .jaddr_sh       (jaddr_sh),
        .jr_addr        (jr_addr),
        .pend_v         (pend_v_reg),
        .pend_tgt       (pend_tgt_reg),
        .live_v         (live_v),
        .live_tgt       (live_tgt),
        .next_pc        (next_pc_raw)
    );

    assign accept = (state_reg == ST_REQ) && imem_ack && !stall;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_reg;
    assign misalign    = misalign_reg;
    assign next_pc_eff = next_pc_raw;
    assign align_fault = accept && (next_pc_raw[1:0] != 2'b00);
    assign halted      = misalign_reg;
`else
    // Without the check, unaligned targets silently lose their low bits.
    assign next_pc_eff = next_pc_raw & ~XLEN'(3);
    assign align_fault = 1'b0;
    assign halted      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_VEC;
            req_reg      <= 1'b0;
            pend_v_reg   <= 1'b0;
            pend_tgt_reg <= '0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_BOOT: begin
                    state_reg <= ST_REQ;
                    req_reg   <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        if (stall || align_fault) begin
                            state_reg <= ST_HOLD;
                            req_reg   <= 1'b0;
                        end else begin
                            pc_reg <= next_pc_eff;
                        end
                    end
                end
                ST_HOLD: begin
                    // Re-issue the same pc; a misalign halt only leaves via reset.
                    if (!stall && !halted) begin
                        state_reg <= ST_REQ;
                        req_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_BOOT;
                    req_reg   <= 1'b0;
                end
            endcase

            if (accept && !align_fault) begin
                pend_v_reg <= 1'b0;
            end else if (live_v) begin
                pend_v_reg   <= 1'b1;
                pend_tgt_reg <= live_tgt;
            end

`ifdef PC_ALIGN_CHECK_EN
            if (align_fault)
                misalign_reg <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_pc_next_fetch.sv
// Scoreboard bench for pc_next_fetch: expected fetch addresses are queued by the stimulus
// and checked by a monitor on every accepted (req & ack) fetch.
module tb_pc_next_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [1:0]  pc_src;
    logic [31:0] br_off;
    logic [27:0] jaddr_sh;
    logic [31:0] jr_addr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_q[$];

    pc_next_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .pc_src         (pc_src),
        .br_off         (br_off),
        .jaddr_sh       (jaddr_sh),
        .jr_addr        (jr_addr),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
`ifdef PC_ALIGN_CHECK_EN
        .misalign       (misalign),
`endif
        .pc             (pc),
        .pc_plus4       (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: every accepted fetch must match the next queued address.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ack) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL fetch_unexpected: got 0x%08h expected none", imem_addr);
            end else begin
                check("fetch_addr", imem_addr, exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; push=1 queues the address the accepted fetch must carry.
    task automatic step(input bit push, input logic [31:0] exp_addr, input logic ack,
                        input logic stl, input logic rv, input logic [1:0] src,
                        input logic [31:0] tgt);
        if (push) exp_q.push_back(exp_addr);
        imem_ack       = ack;
        stall          = stl;
        redirect_valid = rv;
        pc_src         = src;
        jr_addr        = tgt;
        br_off         = tgt;
        jaddr_sh       = tgt[27:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 0, 0, 2'b00, 0);
        check("reset_req", {31'd0, imem_req}, 32'h0);
        check("reset_pc", pc, 32'h0);
        check("reset_pc_plus4", pc_plus4, 32'h4);
        rst_n = 1'b1;

        // Boot cycle, then sequential fetches 0,4,8,C.
        step(0, 0, 1, 0, 0, 2'b00, 0);
        step(1, 32'h0, 1, 0, 0, 2'b00, 0);
        step(1, 32'h4, 1, 0, 0, 2'b00, 0);
        step(1, 32'h8, 1, 0, 0, 2'b00, 0);
        step(1, 32'hC, 1, 0, 0, 2'b00, 0);

        // jr to 0x1000_0000, jump field 0x40, jr 0x100, branch -16, then seq.
        step(1, 32'h10,        1, 0, 1, 2'b11, 32'h1000_0000);
        step(1, 32'h1000_0000, 1, 0, 1, 2'b10, 32'h0000_0040);
        step(1, 32'h1000_0040, 1, 0, 1, 2'b11, 32'h0000_0100);
        step(1, 32'h100,       1, 0, 1, 2'b01, 32'hFFFF_FFF0);
        step(1, 32'hF4,        1, 0, 0, 2'b00, 0);

        // Ack low 3 cycles; newer pending redirect (0x300) wins.
        step(0, 0, 0, 0, 1, 2'b11, 32'h200);
        step(0, 0, 0, 0, 1, 2'b11, 32'h300);
        step(0, 0, 0, 0, 0, 2'b00, 0);
        step(1, 32'hF8,  1, 0, 0, 2'b00, 0);
        step(1, 32'h300, 1, 0, 1, 2'b11, 32'h40);

        // Stall with ack at 0x40 -> HOLD; redirect during HOLD applied after re-issue.
        step(1, 32'h40, 1, 1, 0, 2'b00, 0);
        check("hold_req", {31'd0, imem_req}, 32'h0);
        step(0, 0, 1, 1, 1, 2'b11, 32'h80);
        check("hold_pc", pc, 32'h40);
        step(0, 0, 1, 0, 0, 2'b00, 0);
        check("reissue_req", {31'd0, imem_req}, 32'h1);
        step(1, 32'h40, 1, 0, 0, 2'b00, 0);
        step(1, 32'h80, 1, 0, 1, 2'b11, 32'hFFFF_FFFC);

        // Wrap at top of address space.
        step(1, 32'hFFFF_FFFC, 1, 0, 0, 2'b00, 0);
        step(1, 32'h0,         1, 0, 0, 2'b00, 0);
        check("wrap_pc", pc, 32'h4);

        // Reset mid-fetch with a pending redirect: both discarded.
        step(0, 0, 0, 0, 1, 2'b11, 32'h500);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", {31'd0, imem_req}, 32'h0);
        check("rst_mid_pc", pc, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 1, 0, 0, 2'b00, 0);
        step(1, 32'h0, 1, 0, 0, 2'b00, 0);
        check("no_stale_redirect", pc, 32'h4);

        // Unaligned jr target.
        step(1, 32'h4, 1, 0, 1, 2'b11, 32'h202);
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_set", {31'd0, misalign}, 32'h1);
        check("misalign_pc", pc, 32'h4);
        step(0, 0, 1, 0, 0, 2'b00, 0);
        step(0, 0, 1, 0, 0, 2'b00, 0);
        check("misalign_req", {31'd0, imem_req}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("misalign_clear", {31'd0, misalign}, 32'h0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 2'b00, 0);
`else
        check("align_drop_pc", pc, 32'h200);
        step(0, 0, 0, 0, 0, 2'b00, 0);
`endif

        check("queue_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
